// File: rtl/seq_addsub_digit_if.sv
// Start/done handshake bundle for the digit-serial adder/subtractor.
// The master drives the operation request; the slave returns status and result.
interface seq_addsub_digit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/seq_addsub_digit.sv
// Digit-serial adder/subtractor: one DIGIT-bit ripple slice per clock with a
// registered carry, start/done handshake, carry-out and signed overflow.
module seq_addsub_digit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  seq_addsub_digit_if.slave  bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_carry;
  logic [CNT_W-1:0] r_count;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [WIDTH-1:0] w_beff;
  logic [DIGIT-1:0] w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_part_next;
  logic             w_accept;
  logic             w_last;

  // Subtraction is a + ~b + 1: invert B here and seed the carry with sub.
  assign w_beff   = bus.b ^ {WIDTH{bus.sub}};
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_count == LAST_CNT);

  // Ripple-carry slice over the low DIGIT bits of the operand shifters.
  always_comb begin : ripple
    logic v_c;
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so the carry chain evaluates in order and no latch forms.
    v_c = r_carry;
    w_s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      w_s[i] = r_op_a[i] ^ r_op_b[i] ^ v_c;
      v_c    = (r_op_a[i] & r_op_b[i]) | (v_c & (r_op_a[i] ^ r_op_b[i]));
    end
    w_c = v_c;
  end

  // Partial result: new digit enters at the top, older digits move down.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_part_next = w_s;
    end else begin : g_multi
      logic [WIDTH-DIGIT-1:0] r_part;

      assign w_part_next = {w_s, r_part};

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_part <= '0;
        end else if (r_state == S_RUN) begin
          r_part <= w_part_next[WIDTH-1:DIGIT];
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  w_state_next = bus.start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking '<=' and every register, datapath
    // included, is cleared by the synchronous reset so an abort leaves no stale state.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op_a  <= bus.a;
        r_op_b  <= w_beff;
        r_carry <= bus.sub;
        r_count <= '0;
        r_a_msb <= bus.a[WIDTH-1];
        r_b_msb <= w_beff[WIDTH-1];
      end else if (r_state == S_RUN) begin
        r_op_a  <= r_op_a >> DIGIT;
        r_op_b  <= r_op_b >> DIGIT;
        r_carry <= w_c;
        r_count <= r_count + CNT_W'(1);
        // Results update only on the last slice so they hold steady during RUN.
        if (w_last) begin
          r_sum  <= w_part_next;
          r_cout <= w_c;
          r_ovf  <= (r_a_msb == r_b_msb) && (w_part_next[WIDTH-1] != r_a_msb);
        end
      end
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule
